fpu_lzd_norm_shifter: RTL



---
 rtl/fpu_lzd_norm_shifter_pkg.sv | 25 ++
 rtl/fpu_lzd_norm_shifter_if.sv | 24 ++
 rtl/fpu_lzd_merge.sv | 14 +
 rtl/fpu_lzd_norm_shifter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fpu_lzd_norm_shifter_pkg.sv
// Shared LZD constants: operand/count widths, pair-vector layout and nibble merge helper.
package fpu_lzd_norm_shifter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned PAIR_CNT = 16;
  localparam int unsigned NIB_CNT  = PAIR_CNT / 2;
  localparam int unsigned BYTE_CNT = NIB_CNT / 2;
  localparam int unsigned VAL_OFS  = 1;
  localparam int unsigned POS_OFS  = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] cnt;
  } lzd_nib_t;

  // Merge two adjacent {val,pos} pairs (hi pair in pv[3:2]) into a nibble result.
  function automatic lzd_nib_t lzd_nib(input logic [3:0] pv);
    lzd_nib_t r;
    r.v   = pv[2+VAL_OFS] | pv[VAL_OFS];
    r.cnt = pv[2+VAL_OFS] ? {1'b0, pv[2+POS_OFS]} : {1'b1, pv[POS_OFS]};
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzd_norm_shifter_if.sv
// Valid/ready stream carrying the integer + pair vector in and the normalized result out.
interface fpu_lzd_norm_shifter_if;
  import fpu_lzd_norm_shifter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_pos_val;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_norm;
  logic [CNT_W-1:0]  out_lzc;
  logic              out_zero;

  modport master (
    output in_valid, in_data, in_pos_val, out_ready,
    input  in_ready, out_valid, out_norm, out_lzc, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_pos_val, out_ready,
    output in_ready, out_valid, out_norm, out_lzc, out_zero
  );
endinterface

// File: rtl/fpu_lzd_merge.sv
// Hi/lo merge cell: combines two W-bit leading-zero counts into one (W+1)-bit count.
module fpu_lzd_merge #(
  parameter int unsigned W = 2
) (
  input  logic         v_hi,
  input  logic [W-1:0] cnt_hi,
  input  logic         v_lo,
  input  logic [W-1:0] cnt_lo,
  output logic         v,
  output logic [W:0]   cnt
);
  assign v   = v_hi | v_lo;
  assign cnt = v_hi ? {1'b0, cnt_hi} : {1'b1, cnt_lo};
endmodule

// File: rtl/fpu_lzd_norm_shifter.sv
// 3-stage pipeline: pair vector -> byte counts -> full LZC -> left-normalized integer.
module fpu_lzd_norm_shifter
  import fpu_lzd_norm_shifter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  fpu_lzd_norm_shifter_if.slave bus
);

  lzd_nib_t          nib [NIB_CNT];
  logic [BYTE_CNT-1:0] byte_v;
  logic [2:0]        byte_cnt [BYTE_CNT];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [BYTE_CNT-1:0] s1_bv;
  logic [2:0]        s1_bcnt [BYTE_CNT];

  logic [1:0]        half_v;
  logic [3:0]        half_cnt [2];
  logic              word_v;
  logic [4:0]        word_cnt;
  logic [CNT_W-1:0]  lzc_c;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [CNT_W-1:0]  s2_lzc;
  logic              s2_zero;

  logic              out_valid;
  logic [DATA_W-1:0] out_norm;
  logic [CNT_W-1:0]  out_lzc;
  logic              out_zero;

  logic              out_en;
  logic              s2_en;
  logic              s1_en;

  // Each stage may load when the stage after it is empty or moving on this cycle.
  assign out_en = ~out_valid | bus.out_ready;
  assign s2_en  = ~s2_valid | out_en;
  assign s1_en  = ~s1_valid | s2_en;

  always_comb begin
    for (int n = 0; n < NIB_CNT; n++) begin
      nib[n] = lzd_nib(bus.in_pos_val[4*n +: 4]);
    end
  end

  for (genvar b = 0; b < BYTE_CNT; b++) begin : g_byte
    fpu_lzd_merge #(.W(2)) u_byte (
      .v_hi   (nib[2*b+1].v),
      .cnt_hi (nib[2*b+1].cnt),
      .v_lo   (nib[2*b].v),
      .cnt_lo (nib[2*b].cnt),
      .v      (byte_v[b]),
      .cnt    (byte_cnt[b])
    );
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    fpu_lzd_merge #(.W(3)) u_half (
      .v_hi   (s1_bv[2*h+1]),
      .cnt_hi (s1_bcnt[2*h+1]),
      .v_lo   (s1_bv[2*h]),
      .cnt_lo (s1_bcnt[2*h]),
      .v      (half_v[h]),
      .cnt    (half_cnt[h])
    );
  end

  fpu_lzd_merge #(.W(4)) u_word (
    .v_hi   (half_v[1]),
    .cnt_hi (half_cnt[1]),
    .v_lo   (half_v[0]),
    .cnt_lo (half_cnt[0]),
    .v      (word_v),
    .cnt    (word_cnt)
  );

  assign lzc_c = word_v ? CNT_W'(word_cnt) : CNT_W'(DATA_W);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bv     <= '0;
      for (int b = 0; b < BYTE_CNT; b++) s1_bcnt[b] <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_lzc    <= '0;
      s2_zero   <= 1'b0;
      out_valid <= 1'b0;
      out_norm  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_bv   <= byte_v;
          for (int b = 0; b < BYTE_CNT; b++) s1_bcnt[b] <= byte_cnt[b];
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_lzc  <= lzc_c;
          s2_zero <= ~word_v;
        end
      end
      if (out_en) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_norm <= s2_zero ? '0 : s2_data << s2_lzc[4:0];
          out_lzc  <= s2_lzc;
          out_zero <= s2_zero;
        end
      end
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = out_valid;
  assign bus.out_norm  = out_norm;
  assign bus.out_lzc   = out_lzc;
  assign bus.out_zero  = out_zero;

endmodule
